muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer_if.sv | 34 +++
 rtl/muldiv_sequencer.sv | 110 +++++++++++
 tb/tb_muldiv_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Signal bundle between the execute-stage sequencer, the multdiv unit and the
// shared regfile write port. The slave modport is the sequencer's view.
interface muldiv_sequencer_if;
  logic        issue_valid;
  logic        issue_is_div;
  logic [4:0]  issue_rd;
  logic        md_ready;
  logic        md_exception;
  logic [31:0] md_result;
  logic        wb_busy;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic        stall;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        timeout_err;

  modport slave (
    input  issue_valid, issue_is_div, issue_rd,
    input  md_ready, md_exception, md_result,
    input  wb_busy,
    output ctrl_mult, ctrl_div, stall,
    output wr_en, wr_reg, wr_data, timeout_err
  );

  modport master (
    output issue_valid, issue_is_div, issue_rd,
    output md_ready, md_exception, md_result,
    output wb_busy,
    input  ctrl_mult, ctrl_div, stall,
    input  wr_en, wr_reg, wr_data, timeout_err
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences one multiply/divide through multdiv and writes the result back
// when the pipeline frees the regfile port. Define MULDIV_SEQ_TIMEOUT_EN for the WAIT watchdog.
module muldiv_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int RSTATUS = 30
) (
  input  logic          clock,
  input  logic          reset,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT, WRITE} state_t;

  localparam logic [4:0] STATUS_REG = 5'(RSTATUS);

  state_t      state;
  logic        op_div;
  logic [4:0]  rd;
  logic [7:0]  wait_cnt;
  logic        write_ok;
  logic [4:0]  wr_reg_q;
  logic [31:0] wr_data_q;
  logic        ctrl_mult_q;
  logic        ctrl_div_q;
  logic        timeout_q;

`ifdef MULDIV_SEQ_TIMEOUT_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);
`else
  logic unused_watchdog;
  assign unused_watchdog = ^{wait_cnt, 8'(TIMEOUT)};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      op_div      <= 1'b0;
      rd          <= 5'd0;
      wait_cnt    <= 8'd0;
      write_ok    <= 1'b0;
      wr_reg_q    <= 5'd0;
      wr_data_q   <= 32'd0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.issue_valid) begin
            op_div      <= bus.issue_is_div;
            rd          <= bus.issue_rd;
            ctrl_mult_q <= !bus.issue_is_div;
            ctrl_div_q  <= bus.issue_is_div;
            wait_cnt    <= 8'd0;
            state       <= START;
          end
        end
        START: begin
          ctrl_mult_q <= 1'b0;
          ctrl_div_q  <= 1'b0;
          state       <= WAIT;
        end
        WAIT: begin
          if (bus.md_ready) begin
            state <= WRITE;
            if (bus.md_exception) begin
              wr_reg_q  <= STATUS_REG;
              wr_data_q <= op_div ? 32'd5 : 32'd4;
              write_ok  <= 1'b1;
            end else begin
              wr_reg_q  <= rd;
              wr_data_q <= bus.md_result;
              // r0 is hardwired zero, so a clean result for it is dropped
              write_ok  <= (rd != 5'd0);
            end
`ifdef MULDIV_SEQ_TIMEOUT_EN
          end else if (wait_cnt == WAIT_LIMIT) begin
            state     <= WRITE;
            wr_reg_q  <= STATUS_REG;
            wr_data_q <= 32'd6;
            write_ok  <= 1'b1;
            timeout_q <= 1'b1;
`endif
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WRITE: begin
          if (!bus.wb_busy) begin
            state     <= IDLE;
            write_ok  <= 1'b0;
            wr_reg_q  <= 5'd0;
            wr_data_q <= 32'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The pipeline owns the write port whenever wb_busy is high, so the enable is gated live
  assign bus.wr_en       = write_ok && (state == WRITE) && !bus.wb_busy;
  assign bus.wr_reg      = wr_reg_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.ctrl_mult   = ctrl_mult_q;
  assign bus.ctrl_div    = ctrl_div_q;
  assign bus.stall       = (state != IDLE) || bus.issue_valid;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: drivers push expected regfile writes,
// a negedge monitor pops and compares every write the DUT makes.
module tb_muldiv_sequencer;

`ifdef MULDIV_SEQ_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 64;
`endif
  localparam int RSTATUS = 30;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  wr_t  exp_q[$];

  always #5 clock = ~clock;

  muldiv_sequencer_if bus();

  muldiv_sequencer #(.TIMEOUT(TMO), .RSTATUS(RSTATUS)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: any write the DUT makes must match the oldest expected write
  always @(negedge clock) begin
    wr_t e;
    if (reset && bus.wr_en) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_write: got reg %0d data 0x%08h, expected no write",
                 bus.wr_reg, bus.wr_data);
      end else begin
        e = exp_q.pop_front();
        check_output("write_reg", 32'(bus.wr_reg), 32'(e.r));
        check_output("write_data", bus.wr_data, e.d);
        check_output("write_while_busy", 32'(bus.wb_busy), 32'd0);
      end
    end
  end

  task automatic apply_stimulus(input bit is_div, input logic [4:0] rd, input logic [31:0] result,
                                input bit exc, input int ready_delay, input int busy_cycles);
    bit writes;
    writes = exc || (rd != 5'd0);
    @(posedge clock); #1;
    bus.issue_valid  = 1'b1;
    bus.issue_is_div = is_div;
    bus.issue_rd     = rd;
    if (exc)
      exp_q.push_back(wr_t'{r: 5'(RSTATUS), d: (is_div ? 32'd5 : 32'd4)});
    else if (rd != 5'd0)
      exp_q.push_back(wr_t'{r: rd, d: result});
    @(negedge clock);
    check_output("stall_issue", 32'(bus.stall), 32'd1);

    // START: stray issue and md_ready must be ignored
    @(posedge clock); #1;
    bus.issue_valid  = 1'($urandom_range(0, 1));
    bus.issue_is_div = ~is_div;
    bus.issue_rd     = 5'($urandom);
    bus.md_ready     = 1'b1;
    bus.md_result    = $urandom;
    bus.md_exception = 1'($urandom);
    @(negedge clock);
    check_output("ctrl_mult_pulse", 32'(bus.ctrl_mult), 32'(!is_div));
    check_output("ctrl_div_pulse", 32'(bus.ctrl_div), 32'(is_div));
    check_output("stall_start", 32'(bus.stall), 32'd1);

    @(posedge clock); #1;
    bus.md_ready = 1'b0;
    for (int i = 0; i < ready_delay; i++) begin
      @(negedge clock);
      check_output("ctrl_idle_in_wait", 32'({bus.ctrl_mult, bus.ctrl_div}), 32'd0);
      check_output("no_write_in_wait", 32'(bus.wr_en), 32'd0);
      @(posedge clock); #1;
    end
    bus.md_ready     = 1'b1;
    bus.md_result    = result;
    bus.md_exception = exc;

    @(posedge clock); #1;
    bus.md_ready     = 1'b0;
    bus.md_result    = $urandom;
    bus.md_exception = 1'($urandom);
    bus.wb_busy      = 1'b1;
    for (int i = 0; i < busy_cycles; i++) begin
      @(negedge clock);
      check_output("wr_en_held_busy", 32'(bus.wr_en), 32'd0);
      check_output("stall_write", 32'(bus.stall), 32'd1);
      @(posedge clock); #1;
    end
    bus.wb_busy = 1'b0;
    @(negedge clock);
    check_output("wr_en_write_cycle", 32'(bus.wr_en), 32'(writes));

    @(posedge clock); #1;
    bus.issue_valid = 1'b0;
    @(negedge clock);
    check_output("stall_after", 32'(bus.stall), 32'd0);
    check_output("idle_wr_reg", 32'(bus.wr_reg), 32'd0);
    check_output("idle_wr_data", bus.wr_data, 32'd0);
    check_output("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_stall"}, 32'(bus.stall), 32'd0);
    check_output({tag, "_ctrl"}, 32'({bus.ctrl_mult, bus.ctrl_div}), 32'd0);
    check_output({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    check_output({tag, "_wr_reg"}, 32'(bus.wr_reg), 32'd0);
    check_output({tag, "_wr_data"}, bus.wr_data, 32'd0);
    check_output({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
  endtask

  task automatic reset_mid_wait();
    @(posedge clock); #1;
    bus.issue_valid  = 1'b1;
    bus.issue_is_div = 1'b0;
    bus.issue_rd     = 5'd9;
    @(posedge clock); #1;
    bus.issue_valid = 1'b0;
    bus.md_ready    = 1'b0;
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid_wait");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    bus.md_ready     = 1'b1;
    bus.md_result    = 32'h0000_1234;
    bus.md_exception = 1'b0;
    @(posedge clock); #1;
    bus.md_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_output("post_reset_no_write", 32'(bus.wr_en), 32'd0);
      check_output("post_reset_stall", 32'(bus.stall), 32'd0);
    end
  endtask

`ifdef MULDIV_SEQ_TIMEOUT_EN
  task automatic timeout_abort();
    int n;
    @(posedge clock); #1;
    bus.issue_valid  = 1'b1;
    bus.issue_is_div = 1'b0;
    bus.issue_rd     = 5'd9;
    exp_q.push_back(wr_t'{r: 5'(RSTATUS), d: 32'd6});
    @(posedge clock); #1;
    bus.issue_valid = 1'b0;
    bus.md_ready    = 1'b0;
    bus.wb_busy     = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(negedge clock);
      if (bus.wr_en) break;
    end
    // START cycle, then TMO WAIT cycles, then the write
    check_output("timeout_write_cycle", 32'(n), 32'(TMO + 1));
    @(posedge clock); #1;
    @(negedge clock);
    check_output("timeout_err_set", 32'(bus.timeout_err), 32'd1);
    check_output("timeout_pending", 32'(exp_q.size()), 32'd0);
    apply_stimulus(1'b1, 5'd4, 32'h0000_0077, 1'b0, 1, 0);
    check_output("timeout_err_sticky", 32'(bus.timeout_err), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_output("timeout_err_cleared", 32'(bus.timeout_err), 32'd0);
    @(negedge clock);
    reset = 1'b1;
  endtask
`endif

  initial begin
    bus.issue_valid  = 1'b0;
    bus.issue_is_div = 1'b0;
    bus.issue_rd     = 5'd0;
    bus.md_ready     = 1'b0;
    bus.md_exception = 1'b0;
    bus.md_result    = 32'd0;
    bus.wb_busy      = 1'b0;
    #1 reset = 1'b0;
    #2;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b1;

    apply_stimulus(1'b0, 5'd5, 32'h0000_0030, 1'b0, 0, 0);
    apply_stimulus(1'b1, 5'd7, 32'h0000_00AB, 1'b1, 1, 0);
    apply_stimulus(1'b0, 5'd12, 32'hDEAD_BEEF, 1'b0, 0, 3);
    apply_stimulus(1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 0, 0);
    apply_stimulus(1'b1, 5'd0, 32'h0000_0001, 1'b1, 2, 1);
    reset_mid_wait();

`ifdef MULDIV_SEQ_TIMEOUT_EN
    timeout_abort();
`else
    apply_stimulus(1'b1, 5'd3, 32'h1357_9BDF, 1'b0, 70, 0);
    check_output("timeout_err_tied", 32'(bus.timeout_err), 32'd0);
`endif

    for (int k = 0; k < 40; k++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      apply_stimulus(1'($urandom), rd, $urandom, ($urandom_range(0, 7) == 0),
                     $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no completion, expected finish before 200000 ns");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
